// File: rtl/controller_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : controller_sequencer_if
// Brief    : Opcode in / ring state, 12-bit control word and halt out.
// Revision : 1.0 - initial release
// ============================================================================
interface controller_sequencer_if #(
    parameter int OPCODE_WIDTH = 4
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [5:0]              state;
    logic Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo;
    logic halt;

    modport master (
        input  opcode,
        output state, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halt
    );

    modport slave (
        output opcode,
        input  state, Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, halt
    );
endinterface
`default_nettype wire

// File: rtl/controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : controller_sequencer
// Brief    : SAP-1 six-state ring counter and opcode decoder; optional early
//            ring return enabled by CTRL_SKIP_NOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module controller_sequencer #(
    parameter int OPCODE_WIDTH = 4
) (
    input  wire logic              clk,
    input  wire logic              clear,
    controller_sequencer_if.master bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] C_OP_LDA = OPCODE_WIDTH'(4'b0000);
    localparam logic [OPCODE_WIDTH-1:0] C_OP_ADD = OPCODE_WIDTH'(4'b0001);
    localparam logic [OPCODE_WIDTH-1:0] C_OP_SUB = OPCODE_WIDTH'(4'b0010);
    localparam logic [OPCODE_WIDTH-1:0] C_OP_OUT = OPCODE_WIDTH'(4'b1110);
    localparam logic [OPCODE_WIDTH-1:0] C_OP_HLT = OPCODE_WIDTH'(4'b1111);

    state_t r_state;
    logic   r_halt;

    logic w_is_lda, w_is_add, w_is_sub, w_is_out, w_is_hlt;
    logic w_skip_t4, w_skip_t5;

    assign w_is_lda = (bus.opcode == C_OP_LDA);
    assign w_is_add = (bus.opcode == C_OP_ADD);
    assign w_is_sub = (bus.opcode == C_OP_SUB);
    assign w_is_out = (bus.opcode == C_OP_OUT);
    assign w_is_hlt = (bus.opcode == C_OP_HLT);

`ifdef CTRL_SKIP_NOP_EN
    logic w_is_nop;
    assign w_is_nop  = ~(w_is_lda | w_is_add | w_is_sub | w_is_out | w_is_hlt);
    assign w_skip_t4 = w_is_out | w_is_nop;
    assign w_skip_t5 = w_is_lda;
`else
    assign w_skip_t4 = 1'b0;
    assign w_skip_t5 = 1'b0;
`endif

    // Ring advances on the falling edge so the word is settled for the
    // following high phase, where the datapath loads on the rising edge.
    always_ff @(negedge clk or posedge clear) begin
        if (clear) begin
            r_state <= T1;
            r_halt  <= 1'b0;
        end else if (!r_halt) begin
            case (r_state)
                T1: r_state <= T2;
                T2: r_state <= T3;
                T3: r_state <= T4;
                T4: begin
                    if (w_is_hlt)       r_halt  <= 1'b1;
                    else if (w_skip_t4) r_state <= T1;
                    else                r_state <= T5;
                end
                T5:      r_state <= w_skip_t5 ? T1 : T6;
                default: r_state <= T1;
            endcase
        end
    end

    logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;

    always_comb begin
        {w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo} = 12'b0;
        case (r_state)
            T1: begin w_ep = 1'b1; w_lm = 1'b1; end
            T2: w_cp = 1'b1;
            T3: begin w_ce = 1'b1; w_li = 1'b1; end
            T4: begin
                if (!r_halt) begin
                    if (w_is_lda | w_is_add | w_is_sub) begin
                        w_lm = 1'b1;
                        w_ei = 1'b1;
                    end
                    if (w_is_out) begin
                        w_ea = 1'b1;
                        w_lo = 1'b1;
                    end
                end
            end
            T5: begin
                w_ce = w_is_lda | w_is_add | w_is_sub;
                w_la = w_is_lda;
                w_lb = w_is_add | w_is_sub;
            end
            T6: begin
                w_la = w_is_add | w_is_sub;
                w_eu = w_is_add | w_is_sub;
                w_su = w_is_sub;
            end
            default: ;
        endcase
    end

    assign bus.state = r_state;
    assign bus.Cp    = w_cp;
    assign bus.Ep    = w_ep;
    assign bus.Lm    = w_lm;
    assign bus.CE    = w_ce;
    assign bus.Li    = w_li;
    assign bus.Ei    = w_ei;
    assign bus.La    = w_la;
    assign bus.Ea    = w_ea;
    assign bus.Su    = w_su;
    assign bus.Eu    = w_eu;
    assign bus.Lb    = w_lb;
    assign bus.Lo    = w_lo;
    assign bus.halt  = ((r_state == T4) & w_is_hlt) | r_halt;

endmodule
`default_nettype wire

// File: tb/tb_controller_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_sequencer
// Brief    : Directed scoreboard bench for controller_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_sequencer;

    localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
    localparam int B_LA = 5,  B_EA = 4,  B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;

    logic clk;
    logic clear;
    int   total = 0;
    int   bad   = 0;
    logic [18:0] sb[$];

    controller_sequencer_if #(.OPCODE_WIDTH(4)) bus ();

    controller_sequencer #(.OPCODE_WIDTH(4)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Expected {state, control word, halt} for step t (1..6) of opcode op.
    function automatic logic [18:0] model(input int t, input logic [3:0] op);
        logic [11:0] w;
        logic        h;
        logic        alu;
        w   = '0;
        h   = 1'b0;
        alu = (op == 4'h1) || (op == 4'h2);
        case (t)
            1: begin w[B_EP] = 1'b1; w[B_LM] = 1'b1; end
            2: w[B_CP] = 1'b1;
            3: begin w[B_CE] = 1'b1; w[B_LI] = 1'b1; end
            4: begin
                if (op == 4'h0 || alu) begin w[B_LM] = 1'b1; w[B_EI] = 1'b1; end
                if (op == 4'hE) begin w[B_EA] = 1'b1; w[B_LO] = 1'b1; end
                if (op == 4'hF) h = 1'b1;
            end
            5: begin
                if (op == 4'h0) begin w[B_CE] = 1'b1; w[B_LA] = 1'b1; end
                if (alu)        begin w[B_CE] = 1'b1; w[B_LB] = 1'b1; end
            end
            6: begin
                if (alu) begin w[B_LA] = 1'b1; w[B_EU] = 1'b1; end
                if (op == 4'h2) w[B_SU] = 1'b1;
            end
            default: ;
        endcase
        return {6'(1 << (t - 1)), w, h};
    endfunction

    function automatic int instr_len(input logic [3:0] op);
`ifdef CTRL_SKIP_NOP_EN
        if (op == 4'h0) return 5;
        if (op == 4'h1 || op == 4'h2) return 6;
        return 4;
`else
        return 6;
`endif
    endfunction

    task automatic check(input string tag);
        logic [18:0] obs;
        logic [18:0] exp_v;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=empty-scoreboard expected=entry", tag);
        end else begin
            exp_v = sb.pop_front();
            obs = {bus.state, bus.Cp, bus.Ep, bus.Lm, bus.CE, bus.Li, bus.Ei,
                   bus.La, bus.Ea, bus.Su, bus.Eu, bus.Lb, bus.Lo, bus.halt};
            assert (obs === exp_v) else begin
                bad++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp_v);
            end
        end
    endtask

    // Entered in the low phase while in T1; returns in the low phase at next T1.
    task automatic run_instr(input logic [3:0] op, input string tag);
        int n;
        bus.opcode = op;
        n = instr_len(op);
        for (int t = 1; t <= n; t++) sb.push_back(model(t, op));
        for (int t = 1; t <= n; t++) begin
            check($sformatf("%s_T%0d", tag, t));
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        bus.opcode = 4'h0;
        clear      = 1'b1;
        #2;
        sb.push_back(model(1, 4'h0));
        check("reset_async");
        @(posedge clk);
        #1 clear = 1'b0;
        #1;
        sb.push_back(model(1, 4'h0));
        check("reset_released");

        run_instr(4'h0, "lda");
        run_instr(4'h2, "sub");
        run_instr(4'h1, "add");
        run_instr(4'hE, "out");
        run_instr(4'h5, "nop");

        // Opcode change in T4 must show up with no added cycle.
        bus.opcode = 4'h5;
        repeat (3) @(negedge clk);
        #2;
        sb.push_back(model(4, 4'h5));
        check("latency_nop");
        bus.opcode = 4'hE;
        #1;
        sb.push_back(model(4, 4'hE));
        check("latency_out");
        bus.opcode = 4'h1;
        #1;
        sb.push_back(model(4, 4'h1));
        check("latency_add");
        clear = 1'b1;
        #1;
        sb.push_back(model(1, 4'h1));
        check("clear_t4");
        @(posedge clk);
        #1 clear = 1'b0;

        // Halt: ring freezes in T4 with all controls low.
        @(negedge clk);
        #2;
        bus.opcode = 4'hF;
        sb.push_back(model(2, 4'hF));
        check("hlt_T2");
        @(negedge clk); #2;
        sb.push_back(model(3, 4'hF));
        check("hlt_T3");
        @(negedge clk); #2;
        sb.push_back(model(4, 4'hF));
        check("hlt_T4");
        @(negedge clk); #2;
        bus.opcode = 4'h0;
        for (int i = 0; i < 10; i++) begin
            sb.push_back({6'b001000, 12'b0, 1'b1});
            check($sformatf("halted_%0d", i));
            @(negedge clk);
            #2;
        end
        clear = 1'b1;
        #1;
        sb.push_back(model(1, 4'h0));
        check("clear_halted");
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        #2;

        // Run ADD up to T5 then abort with clear.
        bus.opcode = 4'h1;
        for (int t = 2; t <= 5; t++) begin
            sb.push_back(model(t, 4'h1));
            check($sformatf("add_abort_T%0d", t));
            if (t < 5) begin
                @(negedge clk);
                #2;
            end
        end
        clear = 1'b1;
        #1;
        sb.push_back(model(1, 4'h1));
        check("clear_t5");
        @(posedge clk);
        #1 clear = 1'b0;
        #1;
        run_instr(4'h5, "nop_after_clear");
        sb.push_back(model(1, 4'h5));
        check("final_t1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: observed=no-finish expected=finish");
        $fatal(1, "test done: total=%0d bad=%0d", total, bad);
    end

endmodule
`default_nettype wire
